seven_segment_driver: RTL

Time-multiplexed driver for a common-anode/common-cathode multi-digit seven-segment display. It is the output-side counterpart of the board push-button debouncing path. It takes packed hex nibbles, per-digit enables and decimal points from core logic. It scans one digit at a time with a dead-time blanking interval between digits to prevent ghosting, and drives the display pins from registered outputs.

---
 rtl/seven_segment_driver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seven_segment_driver.sv
// Time-multiplexed seven-segment display driver.
// Each digit owns a slot of p_refresh_cycles clocks: a dark blanking interval
// of p_blank_cycles followed by the lit interval. The digit's inputs are
// captured on the last blanking cycle so the lit pattern is stable for the
// whole slot. All display pins come straight from flops.
module seven_segment_driver #(
    parameter int unsigned p_no_digits      = 4,
    parameter int unsigned p_refresh_cycles = 100000,
    parameter int unsigned p_blank_cycles   = 1000,
    parameter bit          p_active_low     = 1'b1
) (
    input  logic                     i_w_clk,
    input  logic                     i_w_reset,
    input  logic [4*p_no_digits-1:0] i_w_value,
    input  logic [p_no_digits-1:0]   i_w_digit_en,
    input  logic [p_no_digits-1:0]   i_w_dp,
    output logic [p_no_digits-1:0]   o_w_anode,
    output logic [6:0]               o_w_segments,
    output logic                     o_w_dp,
    output logic                     o_w_frame
);

    localparam int unsigned CntW = $clog2(p_refresh_cycles);
    localparam int unsigned IdxW = $clog2(p_no_digits);

    localparam logic [CntW-1:0] LastBlank = CntW'(p_blank_cycles - 1);
    localparam logic [CntW-1:0] LastShow  = CntW'(p_refresh_cycles - 1);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(p_no_digits - 1);

    // Inactive pin levels; XOR-ing an active-high pattern with these gives the pin value.
    localparam logic [p_no_digits-1:0] AnodeOff = {p_no_digits{p_active_low}};
    localparam logic [6:0]             SegOff   = {7{p_active_low}};
    localparam logic                   DpOff    = p_active_low;

    typedef enum logic {StBlank, StShow} state_e;

    state_e                 r_state;
    logic [CntW-1:0]        r_cnt;
    logic [IdxW-1:0]        r_index;
    logic [3:0]             r_hold_nib;
    logic                   r_hold_en;
    logic                   r_hold_dp;
    logic [p_no_digits-1:0] r_anode;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic                   r_frame;

    logic [3:0]             w_in_nib;
    logic [3:0]             w_src_nib;
    logic                   w_src_en;
    logic                   w_src_dp;
    logic [p_no_digits-1:0] w_onehot;
    logic [p_no_digits-1:0] w_lit_anode;
    logic [6:0]             w_lit_seg;
    logic                   w_lit_dp;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign w_in_nib = i_w_value[{r_index, 2'b00} +: 4];
    assign w_onehot = {{(p_no_digits-1){1'b0}}, 1'b1} << r_index;

    // Lit pattern: from live inputs on the capture cycle, from the holding registers during SHOW.
    always_comb begin
        w_src_nib   = (r_state == StBlank) ? w_in_nib : r_hold_nib;
        w_src_en    = (r_state == StBlank) ? i_w_digit_en[r_index] : r_hold_en;
        w_src_dp    = (r_state == StBlank) ? i_w_dp[r_index] : r_hold_dp;
        w_lit_anode = w_src_en ? w_onehot : '0;
        w_lit_seg   = w_src_en ? f_decode(w_src_nib) : 7'h00;
        w_lit_dp    = w_src_en & w_src_dp;
    end

    // Scan FSM: slot counter, digit index, input capture and registered pin drive.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            r_state    <= StBlank;
            r_cnt      <= '0;
            r_index    <= '0;
            r_hold_nib <= 4'h0;
            r_hold_en  <= 1'b0;
            r_hold_dp  <= 1'b0;
            r_anode    <= AnodeOff;
            r_seg      <= SegOff;
            r_dp       <= DpOff;
            r_frame    <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            unique case (r_state)
                StBlank: begin
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == LastBlank) begin
                        r_hold_nib <= w_in_nib;
                        r_hold_en  <= i_w_digit_en[r_index];
                        r_hold_dp  <= i_w_dp[r_index];
                        r_anode    <= w_lit_anode ^ AnodeOff;
                        r_seg      <= w_lit_seg ^ SegOff;
                        r_dp       <= w_lit_dp ^ DpOff;
                        r_frame    <= (r_index == '0);
                        r_state    <= StShow;
                    end
                end
                StShow: begin
                    if (r_cnt == LastShow) begin
                        r_cnt   <= '0;
                        r_index <= (r_index == LastIdx) ? '0 : r_index + IdxW'(1);
                        r_anode <= AnodeOff;
                        r_seg   <= SegOff;
                        r_dp    <= DpOff;
                        r_state <= StBlank;
                    end else begin
                        r_cnt   <= r_cnt + CntW'(1);
                        r_anode <= w_lit_anode ^ AnodeOff;
                        r_seg   <= w_lit_seg ^ SegOff;
                        r_dp    <= w_lit_dp ^ DpOff;
                    end
                end
            endcase
        end
    end

    assign o_w_anode    = r_anode;
    assign o_w_segments = r_seg;
    assign o_w_dp       = r_dp;
    assign o_w_frame    = r_frame;

endmodule
